ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single RAM port (ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate) among NREQ
//  cache-side requesters (icache/dcache ports of both cores). Two-class round-robin: HIPRI
//  requesters (dcaches) always beat LOPRI ones (icaches). Optional 2-word block lock per grant.
//  Sits between the cache/coherence layer and the RAM model, replacing ad-hoc muxing.
// PARAMETERS
//  NREQ       4        number of requesters (index 0..NREQ-1)
//  BURST      2        beats held under one grant when req_blk is set (>=1)
//  TIMEOUT    255      XFER cycles without ACCESS before abort (8-bit counter)
//  HIPRI_MASK 4'b1100  bit i = 1 -> requester i is high-priority class
// PORTS
//  CLK         in   1           clock, rising edge
//  nRST        in   1           synchronous reset, active low
//  req_ren     in   NREQ        per-requester read request
//  req_wen     in   NREQ        per-requester write request (wins over ren if both set)
//  req_blk     in   NREQ        request is a BURST-beat block transfer
//  req_addr    in   NREQ x 32   word address per requester, passed through when granted
//  req_store   in   NREQ x 32   write data per requester
//  req_wait    out  NREQ        1 = stall; 0 for exactly one cycle per completed beat
//  req_load    out  32          ramload broadcast; valid for grantee when its req_wait=0
//  req_err     out  NREQ        one-cycle pulse to grantee on RAM ERROR or timeout
//  ramREN      out  1           RAM read strobe
//  ramWEN      out  1           RAM write strobe
//  ramaddr     out  32          RAM address
//  ramstore    out  32          RAM write data
//  ramload     in   32          RAM read data
//  ramstate    in   2           ramstate_t: FREE, BUSY, ACCESS, ERROR
//  grant       out  $clog2(NREQ) index of current grantee
//  grant_vld   out  1           1 while in XFER
// BEHAVIOUR
//  Reset (nRST=0 at CLK edge): state=IDLE, rr_ptr=0, grant=0, grant_vld=0, beat=0, tmo=0;
//   req_wait all 1, req_err 0, ramREN=ramWEN=0, ramaddr=ramstore=0. Reset mid-XFER aborts
//   silently: no err pulse, no wait drop.
//  FSM IDLE / XFER, registered:
//   IDLE: no RAM strobes. req = ren|wen. If any HIPRI req, pick first HIPRI req at or after
//    rr_ptr (wrapping modulo NREQ); else same scan over LOPRI. On a pick: grant<=pick,
//    beat<=0, tmo<=0, state<=XFER. Request seen in cycle N -> strobes from cycle N+1.
//   XFER (g=grant): ramWEN=req_wen[g]; ramREN=req_ren[g]&~req_wen[g]; ramaddr=req_addr[g];
//    ramstore=req_store[g]. Requester advances addr/data itself after each wait drop.
//    - ramstate==ACCESS: req_wait[g]=0 this cycle; tmo<=0; if beat==last then state<=IDLE,
//      rr_ptr<=g+1 mod NREQ; else beat<=beat+1. last = BURST-1 if req_blk[g] else 0,
//      sampled on the grant cycle (held for the grant).
//    - ramstate==ERROR: req_err[g]=1, req_wait[g] stays 1, state<=IDLE, rr_ptr<=g+1.
//    - otherwise tmo<=tmo+1; at tmo==TIMEOUT treat as ERROR (err pulse, abort, advance).
//    - req_ren[g]|req_wen[g] low in XFER: strobes 0 this cycle, state<=IDLE, rr_ptr<=g+1,
//      no err pulse.
//  Non-grantees: req_wait=1 always. Minimum one IDLE cycle between grants (no back-to-back).
//  Precedence in one XFER cycle: dropped request > ERROR/timeout > ACCESS.
//  Starvation bound: a HIPRI requester waits at most (#HIPRI-1) grants; LOPRI only
//   when no HIPRI requests pending in IDLE.
//  All outputs not listed per state are at reset values. ramaddr/ramstore return to 0 in IDLE.
// TESTING
//  1 req_ren=4'b0001, addr 0x40, ACCESS after 2 BUSY -> grant=0 from cycle 1, ramREN=1,
//    ramaddr=0x40, req_wait[0]=0 in cycle 3 only, IDLE in cycle 4, rr_ptr=1.
//  2 req_ren=4'b0101 (HIPRI 2, LOPRI 0) together -> 2 granted first; 0 after one IDLE cycle.
//  3 HIPRI 2 and 3 requesting continuously, ACCESS every cycle -> grants alternate 2,3,2,3;
//    LOPRI 0 never granted while they request.
//  4 req_wen[3]=1, req_blk[3]=1, addr 0x100 then 0x104, data A/B -> two ramWEN beats, two
//    wait drops, grant held across both; ren=1 on same requester ignored (write wins).
//  5 ramstate=ERROR during XFER for grant 1 -> req_err[1]=1 for one cycle, req_wait[1]=1, IDLE.
//  6 ramstate stuck BUSY -> req_err pulses at tmo==255; nRST=0 mid-XFER -> strobes 0 next cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single RAM port among NREQ cache-side requesters. High-priority requesters
// always win over low-priority ones, and each class rotates round-robin.
module ram_port_arbiter #(
  parameter int              NREQ       = 4,
  parameter int              BURST      = 2,
  parameter int              TIMEOUT    = 255,
  parameter logic [NREQ-1:0] HIPRI_MASK = 4'b1100
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NREQ-1:0]           req_ren,
  input  logic [NREQ-1:0]           req_wen,
  input  logic [NREQ-1:0]           req_blk,
  input  logic [NREQ-1:0][31:0]     req_addr,
  input  logic [NREQ-1:0][31:0]     req_store,
  output logic [NREQ-1:0]           req_wait,
  output logic [31:0]               req_load,
  output logic [NREQ-1:0]           req_err,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [31:0]               ramaddr,
  output logic [31:0]               ramstore,
  input  logic [31:0]               ramload,
  input  logic [1:0]                ramstate,
  output logic [$clog2(NREQ)-1:0]   grant,
  output logic                      grant_vld
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   rr_reg, rr_next;
  logic [BW-1:0]   beat_reg, beat_next;
  logic [7:0]      tmo_reg, tmo_next;
  logic            blk_reg, blk_next;

  logic [NREQ-1:0] req, cand;
  logic            pick_vld;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   grant_inc;
  logic [BW-1:0]   beat_last;
  logic            g_req, tmo_hit;
  logic            ren_c, wen_c, drop_wait, err_pulse;
  logic [31:0]     addr_c, store_c;

  assign req       = req_ren | req_wen;
  assign cand      = |(req & HIPRI_MASK) ? (req & HIPRI_MASK) : (req & ~HIPRI_MASK);
  assign grant_inc = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;
  assign beat_last = blk_reg ? BW'(BURST - 1) : '0;
  assign g_req     = req[grant_reg];
  assign tmo_hit   = (tmo_reg == 8'(TIMEOUT));

  // Scan downwards so the candidate closest to rr_reg is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[(int'(rr_reg) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = GW'((int'(rr_reg) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    beat_next  = beat_reg;
    tmo_next   = tmo_reg;
    blk_next   = blk_reg;
    ren_c      = 1'b0;
    wen_c      = 1'b0;
    addr_c     = '0;
    store_c    = '0;
    drop_wait  = 1'b0;
    err_pulse  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_vld) begin
          state_next = XFER;
          grant_next = pick_idx;
          beat_next  = '0;
          tmo_next   = '0;
          blk_next   = req_blk[pick_idx];
        end
      end
      XFER: begin
        if (!g_req) begin
          state_next = IDLE;
          rr_next    = grant_inc;
        end else begin
          wen_c   = req_wen[grant_reg];
          ren_c   = req_ren[grant_reg] & ~req_wen[grant_reg];
          addr_c  = req_addr[grant_reg];
          store_c = req_store[grant_reg];
          if (ramstate == RS_ERROR || (ramstate != RS_ACCESS && tmo_hit)) begin
            err_pulse  = 1'b1;
            state_next = IDLE;
            rr_next    = grant_inc;
          end else if (ramstate == RS_ACCESS) begin
            drop_wait = 1'b1;
            tmo_next  = '0;
            if (beat_reg == beat_last) begin
              state_next = IDLE;
              rr_next    = grant_inc;
            end else begin
              beat_next = beat_reg + 1'b1;
            end
          end else begin
            tmo_next = tmo_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      rr_reg    <= '0;
      beat_reg  <= '0;
      tmo_reg   <= '0;
      blk_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
      beat_reg  <= beat_next;
      tmo_reg   <= tmo_next;
      blk_reg   <= blk_next;
    end
  end

  // A reset arriving mid-transfer must not leak a wait drop or error pulse.
  assign ramREN    = nRST & ren_c;
  assign ramWEN    = nRST & wen_c;
  assign ramaddr   = nRST ? addr_c : '0;
  assign ramstore  = nRST ? store_c : '0;
  assign req_load  = ramload;
  assign grant     = grant_reg;
  assign grant_vld = (state_reg == XFER);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
      assign req_wait[gi] = ~(nRST & drop_wait & (grant_reg == GW'(gi)));
      assign req_err[gi]  = nRST & err_pulse & (grant_reg == GW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Random and directed stimulus for ram_port_arbiter, checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_ram_port_arbiter;

  localparam int NREQ = 4;
  localparam int BURST = 2;
  localparam logic [3:0] HIPRI = 4'b1100;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [3:0]       req_ren, req_wen, req_blk;
  logic [3:0][31:0] req_addr, req_store;
  logic [3:0]       req_wait, req_err;
  logic [31:0]      req_load;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;
  logic [1:0]       grant;
  logic             grant_vld;

  int n_checks = 0;
  int n_err = 0;

  ram_port_arbiter #(.NREQ(NREQ), .BURST(BURST), .TIMEOUT(255), .HIPRI_MASK(HIPRI)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_blk(req_blk),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load), .req_err(req_err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant(grant), .grant_vld(grant_vld)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: either no owner, or an owner with a number of beats still to complete.
  bit m_ok = 1'b0;
  int m_busy, m_g, m_left, m_tmo, m_rr;

  function automatic int pick(input logic [3:0] req, input int rr);
    logic [3:0] set;
    set = ((req & HIPRI) != 0) ? (req & HIPRI) : (req & ~HIPRI);
    for (int k = 0; k < NREQ; k++)
      if (set[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  initial forever begin
    @(posedge CLK);
    if (!nRST) begin
      m_busy = 0; m_g = 0; m_left = 0; m_tmo = 0; m_rr = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (m_busy == 0) begin
        int p;
        p = pick(req_ren | req_wen, m_rr);
        if (p >= 0) begin
          m_busy = 1; m_g = p; m_tmo = 0;
          m_left = req_blk[p] ? BURST : 1;
        end
      end else if (!(req_ren[m_g] | req_wen[m_g])) begin
        m_busy = 0; m_rr = (m_g + 1) % NREQ;
      end else if (ramstate == 2'd3 || (ramstate != 2'd2 && m_tmo == 255)) begin
        m_busy = 0; m_rr = (m_g + 1) % NREQ;
      end else if (ramstate == 2'd2) begin
        m_tmo = 0;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0; m_rr = (m_g + 1) % NREQ;
        end
      end else begin
        m_tmo = m_tmo + 1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge CLK);
    if (m_ok) begin
      logic [3:0]  e_wait, e_err;
      logic        e_ren, e_wen;
      logic [31:0] e_addr, e_store;
      e_wait = 4'hF; e_err = 4'h0; e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
      if (nRST && m_busy != 0 && (req_ren[m_g] | req_wen[m_g])) begin
        e_wen = req_wen[m_g];
        e_ren = req_ren[m_g] & ~req_wen[m_g];
        e_addr = req_addr[m_g];
        e_store = req_store[m_g];
        if (ramstate == 2'd3 || (ramstate != 2'd2 && m_tmo == 255)) e_err[m_g] = 1'b1;
        else if (ramstate == 2'd2) e_wait[m_g] = 1'b0;
      end
      chk("req_wait", 32'(req_wait), 32'(e_wait));
      chk("req_err", 32'(req_err), 32'(e_err));
      chk("ramREN", 32'(ramREN), 32'(e_ren));
      chk("ramWEN", 32'(ramWEN), 32'(e_wen));
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);
      chk("req_load", req_load, ramload);
      chk("grant_vld", 32'(grant_vld), 32'(m_busy != 0));
      if (m_busy != 0) chk("grant", 32'(grant), 32'(m_g));
      if (e_wait != 4'hF)
        $display("txn beat  req=%0d wen=%0b addr=%h data=%h", m_g, e_wen, e_addr, e_wen ? e_store : ramload);
      if (e_err != 4'h0)
        $display("txn error req=%0d addr=%h", m_g, e_addr);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
    #1;
  endtask

  task automatic quiet(input int n);
    req_ren = '0; req_wen = '0; req_blk = '0; ramstate = 2'd0;
    repeat (n) step();
  endtask

  initial begin
    int hist[$];
    nRST = 1'b0;
    req_ren = '0; req_wen = '0; req_blk = '0; req_addr = '0; req_store = '0;
    ramload = 32'hDEAD_BEEF; ramstate = 2'd0;
    step(); step();
    look();
    chk("rst_wait", 32'(req_wait), 32'hF);
    chk("rst_vld", 32'(grant_vld), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_addr", ramaddr, 32'd0);
    nRST = 1'b1;
    step();

    // Single read, two BUSY cycles then ACCESS.
    req_ren = 4'b0001; req_addr[0] = 32'h40; ramstate = 2'd1;
    look(); chk("t1_c0_vld", 32'(grant_vld), 32'd0);
    step(); look();
    chk("t1_c1_grant", 32'(grant), 32'd0);
    chk("t1_c1_ren", 32'(ramREN), 32'd1);
    chk("t1_c1_addr", ramaddr, 32'h40);
    chk("t1_c1_wait", 32'(req_wait), 32'hF);
    step(); look(); chk("t1_c2_wait", 32'(req_wait), 32'hF);
    step(); ramstate = 2'd2; look(); chk("t1_c3_wait", 32'(req_wait), 32'hE);
    step(); req_ren = '0; look();
    chk("t1_c4_vld", 32'(grant_vld), 32'd0);
    chk("t1_c4_ren", 32'(ramREN), 32'd0);
    quiet(1);

    // High-priority 2 beats low-priority 0; 0 follows after one idle cycle.
    req_ren = 4'b0101; ramstate = 2'd2;
    step(); look();
    chk("t2_first", 32'(grant), 32'd2);
    chk("t2_first_wait", 32'(req_wait), 32'hB);
    step(); req_ren = 4'b0001; look(); chk("t2_gap_vld", 32'(grant_vld), 32'd0);
    step(); look();
    chk("t2_second", 32'(grant), 32'd0);
    chk("t2_second_wait", 32'(req_wait), 32'hE);
    quiet(2);

    // Error response on requester 1.
    req_ren = 4'b0010; ramstate = 2'd1;
    step(); ramstate = 2'd3; look();
    chk("t5_err", 32'(req_err), 32'h2);
    chk("t5_wait", 32'(req_wait), 32'hF);
    step(); req_ren = '0; look();
    chk("t5_vld", 32'(grant_vld), 32'd0);
    chk("t5_err_gone", 32'(req_err), 32'h0);
    quiet(1);

    // Two-beat block write on requester 3; simultaneous read is ignored.
    req_wen = 4'b1000; req_ren = 4'b1000; req_blk = 4'b1000;
    req_addr[3] = 32'h100; req_store[3] = 32'hAAAA_0001; ramstate = 2'd2;
    step(); look();
    chk("t4_b0_grant", 32'(grant), 32'd3);
    chk("t4_b0_wen", 32'(ramWEN), 32'd1);
    chk("t4_b0_ren", 32'(ramREN), 32'd0);
    chk("t4_b0_addr", ramaddr, 32'h100);
    chk("t4_b0_wait", 32'(req_wait), 32'h7);
    step(); req_addr[3] = 32'h104; req_store[3] = 32'hBBBB_0002; look();
    chk("t4_b1_vld", 32'(grant_vld), 32'd1);
    chk("t4_b1_addr", ramaddr, 32'h104);
    chk("t4_b1_store", ramstore, 32'hBBBB_0002);
    chk("t4_b1_wait", 32'(req_wait), 32'h7);
    step(); req_wen = '0; req_ren = '0; req_blk = '0; look();
    chk("t4_end_vld", 32'(grant_vld), 32'd0);
    quiet(1);

    // Two high-priority requesters alternate; low-priority 0 starves meanwhile.
    req_ren = 4'b1101; ramstate = 2'd2;
    for (int c = 0; c < 16; c++) begin
      look();
      if (grant_vld) hist.push_back(int'(grant));
      step();
    end
    chk("t3_count", 32'(hist.size()), 32'd8);
    for (int i = 0; i < hist.size(); i++) begin
      chk("t3_hipri", 32'(hist[i] >= 2), 32'd1);
      if (i > 0) chk("t3_alternate", 32'(hist[i] != hist[i-1]), 32'd1);
    end
    quiet(2);

    // Stuck BUSY times out after 256 transfer cycles.
    req_wen = 4'b0001; ramstate = 2'd1;
    repeat (255) step();
    look(); chk("t6_pre_err", 32'(req_err), 32'h0);
    step(); look();
    chk("t6_tmo_err", 32'(req_err), 32'h1);
    chk("t6_tmo_wait", 32'(req_wait), 32'hF);
    step(); req_wen = '0; look(); chk("t6_tmo_vld", 32'(grant_vld), 32'd0);
    quiet(1);

    // Reset in the middle of a transfer is silent.
    req_ren = 4'b0001; ramstate = 2'd1;
    step(); look(); chk("t6_rst_pre_vld", 32'(grant_vld), 32'd1);
    step(); nRST = 1'b0; ramstate = 2'd2; look();
    chk("t6_rst_wait", 32'(req_wait), 32'hF);
    chk("t6_rst_err", 32'(req_err), 32'h0);
    step(); nRST = 1'b1; req_ren = '0; look();
    chk("t6_rst_vld", 32'(grant_vld), 32'd0);
    chk("t6_rst_ren", 32'(ramREN), 32'd0);
    quiet(1);

    // Randomised traffic with sticky requests.
    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(3) == 0) begin
          req_ren[i] = ($urandom_range(9) < 5);
          req_wen[i] = ($urandom_range(9) < 3);
          req_blk[i] = $urandom_range(1);
        end
        req_addr[i] = $urandom;
        req_store[i] = $urandom;
      end
      ramload = $urandom;
      r = $urandom_range(99);
      ramstate = (r < 45) ? 2'd2 : (r < 85) ? 2'd1 : (r < 92) ? 2'd0 : 2'd3;
      nRST = ($urandom_range(299) != 0);
      step();
    end
    nRST = 1'b1;
    quiet(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
